// File: rtl/sha3_absorb_buffer_if.sv
// Stream-in / block-out bundle between the message source, the absorb
// buffer and the Keccak permutation core.
interface sha3_absorb_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  S_TVALID;
    logic                  S_TREADY;
    logic [DATA_WIDTH-1:0] S_TDATA;
    logic                  S_TLAST;
    logic [1:0]            S_TID;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [1599:0]         blk_data;
    logic                  blk_first;
    logic                  blk_last;
    logic [1:0]            blk_mode;

    modport slave (
        input  S_TVALID, S_TDATA, S_TLAST, S_TID, blk_ready,
        output S_TREADY, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );

    modport master (
        output S_TVALID, S_TDATA, S_TLAST, S_TID, blk_ready,
        input  S_TREADY, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );
endinterface

// File: rtl/sha3_absorb_buffer.sv
// SHA3 absorb front-end: packs stream words into rate-sized blocks,
// applies 0x06..0x80 domain padding and hands blocks to the core.
module sha3_absorb_buffer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    sha3_absorb_buffer_if.slave s
);
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 &&
        DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("DATA_WIDTH must be 8, 16, 32 or 64");
    end

    localparam logic [10:0] DW = 11'(DATA_WIDTH);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

    function automatic logic [10:0] rate_f(input logic [1:0] m);
        case (m)
            2'd0:    rate_f = 11'd1152;
            2'd1:    rate_f = 11'd1088;
            2'd2:    rate_f = 11'd832;
            default: rate_f = 11'd576;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic          rdy_q, rdy_d, vld_q, vld_d;
    logic [1599:0] buf_q, buf_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          first_q, first_d;
    logic          in_msg_q, in_msg_d;
    logic          bfirst_q, bfirst_d;
    logic          blast_q, blast_d;
    logic [1:0]    mode_q, mode_d;

    logic          acc, at_end, done, take;
    logic [1:0]    cur_mode;
    logic [10:0]   rate_c, rate_m, wbit;

    assign acc      = s.S_TVALID & rdy_q;
    assign take     = vld_q & s.blk_ready;
    assign cur_mode = in_msg_q ? mode_q : s.S_TID;
    assign rate_c   = rate_f(cur_mode);
    assign rate_m   = rate_f(mode_q);
    assign wbit     = 11'(cnt_q) * DW;
    assign at_end   = (wbit + DW) == rate_c;
    assign done     = acc & (s.S_TLAST | at_end);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= FILL;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (done) state_d = FULL;
            default: if (take && !pend_q) state_d = FILL;
        endcase
    end

    always_comb begin
        rdy_d = (state_d == FILL);
        vld_d = (state_d == FULL);
    end

    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        first_d  = first_q;
        in_msg_d = in_msg_q;
        mode_d   = mode_q;
        bfirst_d = bfirst_q;
        blast_d  = blast_q;
        if (acc) begin
            mode_d   = cur_mode;
            in_msg_d = !s.S_TLAST;
            cnt_d    = cnt_q + 8'd1;
            buf_d[wbit +: DATA_WIDTH] = s.S_TDATA;
            if (done) begin
                bfirst_d = first_q;
                blast_d  = s.S_TLAST & !at_end;
            end
            // Both ORs land on one byte when the message ends one byte short.
            if (s.S_TLAST && !at_end) begin
                buf_d[wbit + DW +: 8]  = buf_d[wbit + DW +: 8] | 8'h06;
                buf_d[rate_c - 11'd8 +: 8] = buf_d[rate_c - 11'd8 +: 8] | 8'h80;
            end
            if (s.S_TLAST && at_end) pend_d = 1'b1;
        end
        if (take) begin
            buf_d   = '0;
            cnt_d   = '0;
            first_d = blast_q;
            if (pend_q) begin
                buf_d[7:0]              = 8'h06;
                buf_d[rate_m - 11'd8 +: 8] = 8'h80;
                pend_d   = 1'b0;
                bfirst_d = 1'b0;
                blast_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            first_q  <= 1'b1;
            in_msg_q <= 1'b0;
            bfirst_q <= 1'b0;
            blast_q  <= 1'b0;
            mode_q   <= '0;
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            first_q  <= first_d;
            in_msg_q <= in_msg_d;
            bfirst_q <= bfirst_d;
            blast_q  <= blast_d;
            mode_q   <= mode_d;
        end
    end

    assign s.S_TREADY  = rdy_q;
    assign s.blk_valid = vld_q;
    assign s.blk_data  = buf_q;
    assign s.blk_first = bfirst_q;
    assign s.blk_last  = blast_q;
    assign s.blk_mode  = mode_q;
endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// Bench for sha3_absorb_buffer: a 64-bit and an 8-bit instance driven with
// directed tables, hand sequences and random messages against a byte model.
module tb_sha3_absorb_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha3_absorb_buffer_if #(.DATA_WIDTH(64)) ia ();
    sha3_absorb_buffer_if #(.DATA_WIDTH(8))  ib ();

    sha3_absorb_buffer #(.DATA_WIDTH(64)) dut_a (.ACLK(clk), .ARESETn(rst_n), .s(ia));
    sha3_absorb_buffer #(.DATA_WIDTH(8))  dut_b (.ACLK(clk), .ARESETn(rst_n), .s(ib));

    typedef struct {
        logic [1599:0] d;
        logic          f;
        logic          l;
        logic [1:0]    m;
    } blk_t;

    typedef struct {
        int sel;
        int mode;
        int nw;
        int nblk;
        int pb;
        int pv;
        int eb;
    } vec_t;

    blk_t got_a[$], exp_a[$], got_b[$], exp_b[$];
    int nvec = 0;
    int nerr = 0;
    int rdy_mode = 1;
    int gap_max = 0;

    function automatic int rate_bytes(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            default: return 72;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [1599:0] act, input logic [1599:0] want);
        int p;
        nvec++;
        if (act !== want) begin
            p = 0;
            while (p < 1599 && act[p] === want[p]) p++;
            nerr++;
            $display("FAIL %s: got %0h want %0h (low 128 bits, first diff bit %0d)",
                     nm, act[127:0], want[127:0], p);
        end
    endtask

    // Reference: byte stream, append 0x06, zero-fill to the rate, OR 0x80 at the end.
    task automatic model(input logic [7:0] msg[$], input int mode, input int sel);
        int r;
        int nb;
        logic [7:0] p[$];
        r = rate_bytes(mode);
        p = msg;
        p.push_back(8'h06);
        while (p.size() % r != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nb = p.size() / r;
        for (int b = 0; b < nb; b++) begin
            blk_t e;
            e.d = '0;
            for (int i = 0; i < r; i++) e.d[i*8 +: 8] = p[b*r+i];
            e.f = (b == 0);
            e.l = (b == nb - 1);
            e.m = 2'(mode);
            if (sel == 0) exp_a.push_back(e);
            else exp_b.push_back(e);
        end
    endtask

    initial begin
        ia.blk_ready = 1'b0;
        ib.blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                ia.blk_ready = 1'($urandom_range(0, 1));
                ib.blk_ready = 1'($urandom_range(0, 1));
            end else if (rdy_mode == 1) begin
                ia.blk_ready = 1'b1;
                ib.blk_ready = 1'b1;
            end else if (rdy_mode == 2) begin
                ia.blk_ready = 1'b0;
                ib.blk_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ia.blk_valid && ia.blk_ready)
            got_a.push_back('{ia.blk_data, ia.blk_first, ia.blk_last, ia.blk_mode});
        if (rst_n && ib.blk_valid && ib.blk_ready)
            got_b.push_back('{ib.blk_data, ib.blk_first, ib.blk_last, ib.blk_mode});
    end

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, gap_max);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [63:0] w, input logic last, input logic [1:0] id);
        int t;
        idle_gap();
        t = 0;
        ia.S_TVALID = 1'b1;
        ia.S_TDATA = w;
        ia.S_TLAST = last;
        ia.S_TID = id;
        do begin
            @(negedge clk);
            t++;
        end while (!ia.S_TREADY && t < 500);
        if (!ia.S_TREADY) begin
            nvec++;
            nerr++;
            $display("FAIL send_a: S_TREADY stayed %b, want 1 within 500 cycles", ia.S_TREADY);
        end
        @(posedge clk);
        #1;
        ia.S_TVALID = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w, input logic last, input logic [1:0] id);
        int t;
        idle_gap();
        t = 0;
        ib.S_TVALID = 1'b1;
        ib.S_TDATA = w;
        ib.S_TLAST = last;
        ib.S_TID = id;
        do begin
            @(negedge clk);
            t++;
        end while (!ib.S_TREADY && t < 500);
        if (!ib.S_TREADY) begin
            nvec++;
            nerr++;
            $display("FAIL send_b: S_TREADY stayed %b, want 1 within 500 cycles", ib.S_TREADY);
        end
        @(posedge clk);
        #1;
        ib.S_TVALID = 1'b0;
    endtask

    // Later words carry a random TID, which the design must ignore.
    task automatic send_msg(input int sel, input int mode, input int nw, input bit dolast);
        logic [7:0] bytes[$];
        int dwb;
        dwb = (sel == 0) ? 8 : 1;
        for (int k = 0; k < nw; k++) begin
            logic [63:0] w;
            logic [1:0] id;
            logic last;
            w = {$urandom, $urandom};
            id = (k == 0) ? 2'(mode) : 2'($urandom_range(0, 3));
            last = dolast && (k == nw - 1);
            for (int i = 0; i < dwb; i++) bytes.push_back(w[i*8 +: 8]);
            if (sel == 0) send_a(w, last, id);
            else send_b(w[7:0], last, id);
        end
        if (dolast) model(bytes, mode, sel);
    endtask

    task automatic compare(input int sel, input string nm, output int ng, output blk_t lastg);
        blk_t g[$], e[$];
        int t;
        t = 0;
        while (((sel == 0) ? (got_a.size() < exp_a.size()) : (got_b.size() < exp_b.size()))
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        if (sel == 0) begin g = got_a; e = exp_a; got_a.delete(); exp_a.delete(); end
        else begin g = got_b; e = exp_b; got_b.delete(); exp_b.delete(); end
        ng = g.size();
        chk({nm, ".count"}, 1600'(g.size()), 1600'(e.size()));
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            chk($sformatf("%s.b%0d.data", nm, i), g[i].d, e[i].d);
            chk($sformatf("%s.b%0d.first", nm, i), 1600'(g[i].f), 1600'(e[i].f));
            chk($sformatf("%s.b%0d.last", nm, i), 1600'(g[i].l), 1600'(e[i].l));
            chk($sformatf("%s.b%0d.mode", nm, i), 1600'(g[i].m), 1600'(e[i].m));
        end
        lastg.d = '0;
        lastg.f = 1'b0;
        lastg.l = 1'b0;
        lastg.m = 2'd0;
        if (g.size() > 0) lastg = g[g.size()-1];
        @(posedge clk);
        #1;
    endtask

    vec_t tab[10];
    int ng;
    blk_t lg;
    logic [63:0] words[16];
    logic [7:0] mb[$];
    logic [1599:0] snap;

    initial begin
        tab[0] = '{0, 1, 1,   1, 8,   8'h06, 135};
        tab[1] = '{0, 1, 17,  2, 0,   8'h06, 135};
        tab[2] = '{0, 3, 16,  2, 56,  8'h06, 71};
        tab[3] = '{0, 0, 18,  2, 0,   8'h06, 143};
        tab[4] = '{0, 2, 12,  1, 96,  8'h06, 103};
        tab[5] = '{0, 2, 13,  2, 0,   8'h06, 103};
        tab[6] = '{1, 0, 143, 1, 143, 8'h86, 143};
        tab[7] = '{1, 0, 144, 2, 0,   8'h06, 143};
        tab[8] = '{1, 3, 70,  1, 70,  8'h06, 71};
        tab[9] = '{1, 3, 71,  1, 71,  8'h86, 71};

        ia.S_TVALID = 1'b0; ia.S_TDATA = '0; ia.S_TLAST = 1'b0; ia.S_TID = '0;
        ib.S_TVALID = 1'b0; ib.S_TDATA = '0; ib.S_TLAST = 1'b0; ib.S_TID = '0;

        #12;
        chk("rst.tready", 1600'(ia.S_TREADY), 1600'(0));
        chk("rst.valid", 1600'(ia.blk_valid), 1600'(0));
        chk("rst.data", ia.blk_data, 1600'(0));
        chk("rst.first", 1600'(ia.blk_first), 1600'(0));
        chk("rst.last", 1600'(ia.blk_last), 1600'(0));
        chk("rst.mode", 1600'(ia.blk_mode), 1600'(0));
        chk("rst.tready_b", 1600'(ib.S_TREADY), 1600'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.tready_lo", 1600'(ia.S_TREADY), 1600'(0));
        @(negedge clk);
        chk("rel.tready_hi", 1600'(ia.S_TREADY), 1600'(1));
        @(posedge clk);
        #1;

        // One-word message: block visible the cycle after the handshake.
        rdy_mode = 2;
        send_msg(0, 1, 1, 1);
        @(negedge clk);
        chk("lat.valid", 1600'(ia.blk_valid), 1600'(1));
        chk("lat.first", 1600'(ia.blk_first), 1600'(1));
        chk("lat.last", 1600'(ia.blk_last), 1600'(1));
        chk("lat.data", ia.blk_data, exp_a[0].d);
        rdy_mode = 1;
        compare(0, "lat", ng, lg);

        // 17 words in mode 1: pad-only block follows block 1 immediately.
        rdy_mode = 3;
        ia.blk_ready = 1'b0;
        send_msg(0, 1, 17, 1);
        @(negedge clk);
        chk("pad.b0.valid", 1600'(ia.blk_valid), 1600'(1));
        chk("pad.b0.last", 1600'(ia.blk_last), 1600'(0));
        @(posedge clk);
        #1;
        ia.blk_ready = 1'b1;
        @(posedge clk);
        #1;
        ia.blk_ready = 1'b0;
        @(negedge clk);
        chk("pad.b1.valid", 1600'(ia.blk_valid), 1600'(1));
        chk("pad.b1.first", 1600'(ia.blk_first), 1600'(0));
        chk("pad.b1.last", 1600'(ia.blk_last), 1600'(1));
        chk("pad.b1.data", ia.blk_data, exp_a[1].d);
        rdy_mode = 1;
        compare(0, "pad", ng, lg);

        // Backpressure with S_TVALID held and TID switching to 0 mid-message.
        rdy_mode = 2;
        mb.delete();
        for (int k = 0; k < 16; k++) begin
            words[k] = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) mb.push_back(words[k][i*8 +: 8]);
        end
        model(mb, 3, 0);
        snap = exp_a[0].d;
        for (int k = 0; k < 16; k++) begin
            if (k == 9) begin
                ia.S_TVALID = 1'b1;
                ia.S_TDATA = words[k];
                ia.S_TLAST = 1'b0;
                ia.S_TID = 2'd0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp.tready", 1600'(ia.S_TREADY), 1600'(0));
                    chk("bp.valid", 1600'(ia.blk_valid), 1600'(1));
                    chk("bp.data", ia.blk_data, snap);
                end
                @(posedge clk);
                #1;
                rdy_mode = 1;
                ia.blk_ready = 1'b1;
            end
            send_a(words[k], k == 15, (k == 0) ? 2'd3 : 2'd0);
        end
        compare(0, "bp", ng, lg);

        // Directed table, random backpressure and source gaps.
        rdy_mode = 0;
        gap_max = 2;
        for (int v = 0; v < 10; v++) begin
            string nm;
            nm = $sformatf("tab%0d", v);
            send_msg(tab[v].sel, tab[v].mode, tab[v].nw, 1);
            compare(tab[v].sel, nm, ng, lg);
            chk({nm, ".nblk"}, 1600'(ng), 1600'(tab[v].nblk));
            chk({nm, ".pad06"}, 1600'(lg.d[tab[v].pb*8 +: 8]), 1600'(tab[v].pv));
            chk({nm, ".pad80"}, 1600'(lg.d[tab[v].eb*8 +: 8]),
                1600'((tab[v].pb == tab[v].eb) ? 8'h86 : 8'h80));
            chk({nm, ".lastflag"}, 1600'(lg.l), 1600'(1));
        end

        // Reset in the middle of a mode-2 message.
        rdy_mode = 1;
        gap_max = 0;
        send_msg(0, 2, 5, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst.tready", 1600'(ia.S_TREADY), 1600'(0));
        chk("mrst.data", ia.blk_data, 1600'(0));
        chk("mrst.valid", 1600'(ia.blk_valid), 1600'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(0, 1, 1, 1);
        compare(0, "mrst", ng, lg);
        chk("mrst.first", 1600'(lg.f), 1600'(1));

        // Random messages on both widths.
        rdy_mode = 0;
        gap_max = 2;
        for (int r = 0; r < 20; r++)
            begin
                send_msg(0, $urandom_range(0, 3), $urandom_range(1, 40), 1);
                compare(0, $sformatf("rnd_a%0d", r), ng, lg);
            end
        for (int r = 0; r < 4; r++)
            begin
                send_msg(1, $urandom_range(0, 3), $urandom_range(1, 300), 1);
                compare(1, $sformatf("rnd_b%0d", r), ng, lg);
            end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
